// File: rtl/data_sram_responder_pkg.sv
// Shared types and constants for the data-SRAM responder: queue entry layout,
// width helpers and the request size encodings.
package data_sram_responder_pkg;

    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_DEPTH      = 2;
    localparam int DEF_LATENCY    = 2;

    // Largest supported LATENCY; the entry countdown field is sized for it.
    localparam int MAX_LATENCY = 256;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    function automatic int cnt_width(input int latency);
        return (latency > 2) ? $clog2(latency) : 1;
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int CNT_W = cnt_width(MAX_LATENCY);

    typedef struct packed {
        logic             wr;
        logic [31:0]      rdata;
        logic [CNT_W-1:0] countdown;
    } sram_resp_entry_t;

endpackage

// File: rtl/data_sram_responder_queue.sv
// Circular FIFO of outstanding transactions; each slot carries its own
// latency countdown that runs down independently of its queue position.
module sram_resp_queue
    import data_sram_responder_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  sram_resp_entry_t push_entry,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output sram_resp_entry_t head
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int OCC_W = occ_width(DEPTH);

    sram_resp_entry_t entries_q [DEPTH];
    sram_resp_entry_t entries_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count_q == OCC_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = entries_q[rd_ptr_q];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        entries_d = entries_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;

        // Countdowns saturate at zero, so a stalled head simply waits there.
        for (int i = 0; i < DEPTH; i++) begin
            if (entries_q[i].countdown != '0) begin
                entries_d[i].countdown = entries_q[i].countdown - CNT_W'(1);
            end
        end

        if (push_ok) begin
            entries_d[wr_ptr_q] = push_entry;
            wr_ptr_d            = next_ptr(wr_ptr_q);
        end
        if (pop_ok) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + OCC_W'(1);
            2'b01:   count_d = count_q - OCC_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            entries_q <= entries_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: rtl/data_sram_responder.sv
// Data-SRAM slave model: word-addressed RAM with byte-masked writes, and an
// in-order completion queue that returns one data_ok per accepted request.
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int LATENCY    = DEF_LATENCY
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,
    input  logic        addr_stall,
    input  logic        data_stall
);

    localparam int WORDS = 1 << ADDR_WIDTH;

    logic [31:0]           mem [WORDS];
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  handshake;
    logic                  q_full;
    logic                  q_empty;
    sram_resp_entry_t      q_head;
    sram_resp_entry_t      push_entry;

    // Size and the aliased address bits do not affect behaviour.
    logic unused_bits;
    assign unused_bits = ^{data_sram_size, data_sram_addr[31:ADDR_WIDTH+2],
                           data_sram_addr[1:0]};

    assign word_idx = data_sram_addr[ADDR_WIDTH+1:2];

    always_comb begin
        data_sram_addr_ok = data_sram_req & ~q_full & ~addr_stall;
        handshake         = data_sram_req & data_sram_addr_ok & ~reset;

        // Read data is captured at acceptance, so it sees every earlier write.
        push_entry.wr        = data_sram_wr;
        push_entry.rdata     = data_sram_wr ? 32'h0 : mem[word_idx];
        push_entry.countdown = CNT_W'(LATENCY - 1);

        data_sram_data_ok = ~q_empty & (q_head.countdown == '0) & ~data_stall;
        data_sram_rdata   = 32'h0;
        if (data_sram_data_ok && !q_head.wr) begin
            data_sram_rdata = q_head.rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (handshake && data_sram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_wstrb[i]) begin
                    mem[word_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    sram_resp_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (handshake),
        .push_entry (push_entry),
        .pop        (data_sram_data_ok),
        .full       (q_full),
        .empty      (q_empty),
        .head       (q_head)
    );

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: three parameter variants share one stimulus
// bus; only the selected unit is scored at a time.
module tb_data_sram_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_stall;
  logic        data_stall;

  logic        addr_ok_v [3];
  logic        data_ok_v [3];
  logic [31:0] rdata_v   [3];
  int          lat_of    [3] = '{2, 4, 1};

  int          cur;
  logic        addr_ok_m;
  logic        data_ok_m;
  logic [31:0] rdata_m;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n_done   = 0;
  int last_pop = -1;
  int prev_pop = -1;
  int last_acc = -1;
  logic lat_chk = 1'b0;

  logic [31:0] exp_q[$];
  int          acc_q[$];

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [14];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_sram_responder #(.ADDR_WIDTH(10), .DEPTH(2), .LATENCY(2)) u_dut0 (
    .clk(clk), .reset(reset), .data_sram_req(req), .data_sram_wr(wr),
    .data_sram_size(size), .data_sram_wstrb(wstrb), .data_sram_addr(addr),
    .data_sram_wdata(wdata), .data_sram_addr_ok(addr_ok_v[0]),
    .data_sram_data_ok(data_ok_v[0]), .data_sram_rdata(rdata_v[0]),
    .addr_stall(addr_stall), .data_stall(data_stall));

  data_sram_responder #(.ADDR_WIDTH(10), .DEPTH(2), .LATENCY(4)) u_dut1 (
    .clk(clk), .reset(reset), .data_sram_req(req), .data_sram_wr(wr),
    .data_sram_size(size), .data_sram_wstrb(wstrb), .data_sram_addr(addr),
    .data_sram_wdata(wdata), .data_sram_addr_ok(addr_ok_v[1]),
    .data_sram_data_ok(data_ok_v[1]), .data_sram_rdata(rdata_v[1]),
    .addr_stall(addr_stall), .data_stall(data_stall));

  data_sram_responder #(.ADDR_WIDTH(10), .DEPTH(2), .LATENCY(1)) u_dut2 (
    .clk(clk), .reset(reset), .data_sram_req(req), .data_sram_wr(wr),
    .data_sram_size(size), .data_sram_wstrb(wstrb), .data_sram_addr(addr),
    .data_sram_wdata(wdata), .data_sram_addr_ok(addr_ok_v[2]),
    .data_sram_data_ok(data_ok_v[2]), .data_sram_rdata(rdata_v[2]),
    .addr_stall(addr_stall), .data_stall(data_stall));

  always_comb begin
    addr_ok_m = addr_ok_v[cur];
    data_ok_m = data_ok_v[cur];
    rdata_m   = rdata_v[cur];
  end

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (data_ok_m) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_data_ok: actual=1 expected=0 (cycle %0d)", cyc);
        end else begin
          logic [31:0] e;
          int a;
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          chk("rdata", rdata_m, e);
          if (lat_chk) chk("latency", 32'(cyc - a), 32'(lat_of[cur] - 1));
        end
        prev_pop = last_pop;
        last_pop = cyc;
        n_done++;
      end else begin
        chk("rdata_idle_zero", rdata_m, 32'h0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the handshake edge.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] e);
    req = 1'b1; wr = w; addr = a; wdata = d; wstrb = s; size = 2'd2;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (addr_ok_m) begin
        exp_q.push_back(w ? 32'h0 : e);
        acc_q.push_back(cyc + 1);
        last_acc = cyc + 1;
        @(posedge clk); #1;
        req = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    req = 1'b0;
    chk("issue_timeout", 32'h0, 32'h1);
  endtask

  task automatic drain();
    for (int n = 0; n < 200; n++) begin
      if (exp_q.size() == 0) return;
      @(posedge clk); #1;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'h0);
  endtask

  task automatic pulse_reset(input int unit);
    reset = 1'b1; req = 1'b0; addr_stall = 1'b0; data_stall = 1'b0;
    cur = unit;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    acc_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c;
    int acc_a;
    int n_before;
    logic [31:0] rnd [8];

    reset = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd0; wstrb = 4'h0;
    addr = '0; wdata = '0; addr_stall = 1'b0; data_stall = 1'b0; cur = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      chk("reset_addr_ok", {31'h0, addr_ok_v[u]}, 32'h0);
      chk("reset_data_ok", {31'h0, data_ok_v[u]}, 32'h0);
      chk("reset_rdata", rdata_v[u], 32'h0);
    end
    @(posedge clk); #1;

    // Table-driven back-to-back traffic on the default unit.
    vecs[0]  = '{1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0100, 32'h0,         4'h0, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 32'h0000_0200, 32'h1122_3344, 4'hF, 32'h0};
    vecs[3]  = '{1'b1, 32'h0000_0200, 32'hAAAA_AAAA, 4'h4, 32'h0};
    vecs[4]  = '{1'b0, 32'h0000_0200, 32'h0,         4'h0, 32'h11AA_3344};
    vecs[5]  = '{1'b1, 32'h0000_0204, 32'h0102_0304, 4'hF, 32'h0};
    vecs[6]  = '{1'b1, 32'h0000_0204, 32'hFFFF_FFFF, 4'h0, 32'h0};
    vecs[7]  = '{1'b0, 32'h0000_0207, 32'h0,         4'h0, 32'h0102_0304};
    vecs[8]  = '{1'b1, 32'h0000_0204, 32'hCAFE_F00D, 4'h3, 32'h0};
    vecs[9]  = '{1'b0, 32'h0000_0204, 32'h0,         4'h0, 32'h0102_F00D};
    vecs[10] = '{1'b1, 32'h1000_0008, 32'h1357_2468, 4'hF, 32'h0};
    vecs[11] = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 32'h1357_2468};
    vecs[12] = '{1'b1, 32'h0000_0100, 32'h5500_0000, 4'h8, 32'h0};
    vecs[13] = '{1'b0, 32'h0000_0100, 32'h0,         4'h0, 32'h55AD_BEEF};
    lat_chk = 1'b1;
    for (int i = 0; i < 14; i++) begin
      issue(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].exp_rdata);
    end
    drain();
    lat_chk = 1'b0;

    // data_stall holds two completed reads until it drops.
    data_stall = 1'b1;
    issue(1'b0, 32'h100, 32'h0, 4'h0, 32'h55AD_BEEF);
    issue(1'b0, 32'h200, 32'h0, 4'h0, 32'h11AA_3344);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_data_ok_low", {31'h0, data_ok_m}, 32'h0);
      @(posedge clk); #1;
    end
    c = cyc;
    data_stall = 1'b0;
    drain();
    chk("stall_first_pop", 32'(prev_pop), 32'(c));
    chk("stall_second_pop", 32'(last_pop), 32'(c + 1));

    // Reset discards outstanding reads but keeps RAM contents.
    issue(1'b1, 32'h300, 32'h5A5A_5A5A, 4'hF, 32'h0);
    drain();
    data_stall = 1'b1;
    issue(1'b0, 32'h300, 32'h0, 4'h0, 32'h5A5A_5A5A);
    issue(1'b0, 32'h100, 32'h0, 4'h0, 32'h55AD_BEEF);
    n_before = n_done;
    pulse_reset(0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_reset_data_ok", {31'h0, data_ok_m}, 32'h0);
      @(posedge clk); #1;
    end
    chk("post_reset_no_completion", 32'(n_done), 32'(n_before));
    c = cyc;
    issue(1'b0, 32'h300, 32'h0, 4'h0, 32'h5A5A_5A5A);
    chk("post_reset_addr_ok", 32'(last_acc), 32'(c + 1));
    drain();

    // Full queue on the LATENCY=4 unit: third request waits for first pop.
    pulse_reset(1);
    issue(1'b1, 32'h000, 32'hA0A0_A0A0, 4'hF, 32'h0);
    issue(1'b1, 32'h004, 32'hB1B1_B1B1, 4'hF, 32'h0);
    issue(1'b1, 32'h008, 32'hC2C2_C2C2, 4'hF, 32'h0);
    drain();
    n_before = n_done;
    issue(1'b0, 32'h000, 32'h0, 4'h0, 32'hA0A0_A0A0);
    acc_a = last_acc;
    issue(1'b0, 32'h004, 32'h0, 4'h0, 32'hB1B1_B1B1);
    chk("full_second_accept", 32'(last_acc - acc_a), 32'd1);
    issue(1'b0, 32'h008, 32'h0, 4'h0, 32'hC2C2_C2C2);
    chk("full_third_accept", 32'(last_acc - acc_a), 32'd5);
    drain();
    chk("full_three_completions", 32'(n_done - n_before), 32'd3);

    // addr_stall, then LATENCY=1 sequential reads.
    pulse_reset(2);
    addr_stall = 1'b1;
    req = 1'b1; wr = 1'b0; addr = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("addr_stall_addr_ok", {31'h0, addr_ok_m}, 32'h0);
      @(posedge clk); #1;
    end
    req = 1'b0;
    addr_stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rnd[i] = $urandom();
      issue(1'b1, 32'(i * 4) + 32'h40, rnd[i], 4'hF, 32'h0);
    end
    drain();
    lat_chk = 1'b1;
    for (int i = 0; i < 8; i++) begin
      issue(1'b0, 32'(i * 4) + 32'h40, 32'h0, 4'h0, rnd[i]);
    end
    drain();
    lat_chk = 1'b0;

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
